// File: rtl/rr_grant_arbiter_8ch.sv
// Round-robin arbiter: picks one requesting channel, restarts the grant-window counter,
// holds a one-hot grant for the window, then rotates priority past the served channel.
module rr_grant_arbiter_8ch #(
  parameter int NCH = 8,
  parameter int IDW = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [NCH-1:0] req,
  input  logic           gnt_done,
  input  logic           count_done,
  output logic           count_reset,
  output logic [NCH-1:0] gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, START, GRANT, RELEASE} state_t;

  state_t         state;
  logic [NCH-1:0] gnt_q;
  logic [IDW-1:0] last_id;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] base_id;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] next_id;
  logic           next_hit;

  // In RELEASE last_id is still being updated, so rotate from the channel just served.
  always_comb begin
    base_id  = (state == RELEASE) ? win_id : last_id;
    next_id  = base_id;
    next_hit = 1'b0;
    cand     = base_id;
    for (int i = 1; i <= NCH; i++) begin
      cand = base_id + IDW'(i);
      if (!next_hit && req[cand]) begin
        next_hit = 1'b1;
        next_id  = cand;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      gnt_q       <= '0;
      count_reset <= 1'b1;
      last_id     <= '1;
      win_id      <= '0;
      gnt_id      <= '0;
    end else begin
      // count_reset is high exactly for the cycle spent in START.
      count_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (next_hit) begin
            win_id      <= next_id;
            gnt_id      <= next_id;
            count_reset <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          gnt_q <= {{(NCH-1){1'b0}}, 1'b1} << win_id;
          state <= GRANT;
        end
        GRANT: begin
          if (count_done || !req[win_id]) begin
            gnt_q <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          last_id <= win_id;
          if (next_hit) begin
            win_id      <= next_id;
            gnt_id      <= next_id;
            count_reset <= 1'b1;
            state       <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The count_done cycle has gnt_done low, which gives a guard cycle with no grant.
  assign gnt       = (state == GRANT) ? (gnt_q & {NCH{gnt_done}}) : '0;
  assign gnt_valid = |gnt;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rr_grant_arbiter_8ch.sv
// Bench for rr_grant_arbiter_8ch with a 0..9 grant-window counter model attached.
module tb_rr_grant_arbiter_8ch;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic       gnt_done;
  logic       count_done;
  logic       count_reset;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [3:0] cnt;

  always #5 Clk = ~Clk;

  // Grant-window counter: free-running 0..9, async reset by count_reset.
  always_ff @(posedge Clk or posedge count_reset) begin
    if (count_reset) cnt <= 4'd0;
    else             cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
  end
  assign gnt_done   = (cnt < 4'd9);
  assign count_done = (cnt == 4'd9);

  rr_grant_arbiter_8ch dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req        (req),
    .gnt_done   (gnt_done),
    .count_done (count_done),
    .count_reset(count_reset),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_valid  (gnt_valid),
    .busy       (busy)
  );

  // Called at a falling edge; leaves reset released with req applied.
  task automatic do_reset(input logic [7:0] r);
    Reset = 1'b1;
    req   = 8'h00;
    repeat (2) @(negedge Clk);
    req   = r;
    Reset = 1'b0;
  endtask

  // Steps falling edges until gnt_valid is seen; ok=0 if the budget runs out.
  task automatic wait_valid(output bit ok, output int steps);
    ok    = 1'b0;
    steps = 0;
    while (!gnt_valid && steps < 40) begin
      @(negedge Clk);
      steps++;
    end
    ok = gnt_valid;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    req   = 8'hFF;
    repeat (3) @(negedge Clk);
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%h valid=%b busy=%b, required gnt=00 valid=0 busy=0", gnt, gnt_valid, busy);
    end
    checks++;
    if (count_reset !== 1'b1 || gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL reset_cr_id: count_reset=%b gnt_id=%0d, required 1 and 0", count_reset, gnt_id);
    end
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b1 || count_reset !== 1'b1 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_start: busy=%b count_reset=%b gnt=%h, required 1 1 00", busy, count_reset, gnt);
    end
    @(negedge Clk);
    checks++;
    if (gnt !== 8'h01 || gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%h gnt_id=%0d valid=%b, required 01 0 1", gnt, gnt_id, gnt_valid);
    end
  endtask

  task automatic test_single;
    logic [7:0] exp_gnt;
    logic       exp_cr;
    do_reset(8'h08);
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      exp_gnt = ((c >= 2 && c <= 10) || c == 14) ? 8'h08 : 8'h00;
      exp_cr  = (c == 1 || c == 13);
      checks++;
      if (gnt !== exp_gnt || count_reset !== exp_cr || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_cycle%0d: gnt=%h count_reset=%b busy=%b, required gnt=%h count_reset=%b busy=1",
                 c, gnt, count_reset, busy, exp_gnt, exp_cr);
      end
    end
  endtask

  task automatic test_all_requesting;
    bit ok;
    int steps;
    int len;
    logic [2:0] exp_id;
    logic [7:0] exp_oh;
    do_reset(8'hFF);
    for (int k = 0; k < 9; k++) begin
      exp_id = 3'(k % 8);
      exp_oh = 8'h01 << exp_id;
      wait_valid(ok, steps);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL all_timeout window %0d: no grant seen, required grant to %0d", k, exp_id);
        return;
      end
      if (k > 0) begin
        checks++;
        if (steps !== 3) begin
          errors++;
          $display("FAIL all_gap window %0d: gap=%0d cycles, required 3", k, steps);
        end
      end
      checks++;
      if (gnt_id !== exp_id || gnt !== exp_oh) begin
        errors++;
        $display("FAIL all_order window %0d: gnt_id=%0d gnt=%h, required %0d %h", k, gnt_id, gnt, exp_id, exp_oh);
      end
      len = 0;
      while (gnt_valid && len < 20) begin
        @(negedge Clk);
        len++;
      end
      checks++;
      if (len !== 9) begin
        errors++;
        $display("FAIL all_len window %0d: %0d grant cycles, required 9", k, len);
      end
    end
  endtask

  task automatic test_early_drop;
    bit ok;
    int steps;
    do_reset(8'h20);
    wait_valid(ok, steps);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drop_timeout: no grant seen, required grant to 5");
      return;
    end
    repeat (4) @(negedge Clk);
    #1 req = 8'h00;
    #1;
    checks++;
    if (gnt !== 8'h20) begin
      errors++;
      $display("FAIL drop_same_cycle: gnt=%h, required 20", gnt);
    end
    @(negedge Clk);
    checks++;
    if (gnt !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_release: gnt=%h busy=%b, required 00 1", gnt, busy);
    end
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL drop_idle: busy=%b gnt=%h, required 0 00", busy, gnt);
    end
    // last_id=5 means channel 6 beats channels 0 and 5.
    req = 8'h61;
    wait_valid(ok, steps);
    checks++;
    if (!ok || gnt_id !== 3'd6 || gnt !== 8'h40) begin
      errors++;
      $display("FAIL drop_last_id: gnt_id=%0d gnt=%h, required 6 40", gnt_id, gnt);
    end
  endtask

  task automatic test_wrap_around;
    bit ok;
    int steps;
    int len;
    logic [2:0] exp_seq [3];
    exp_seq[0] = 3'd7;
    exp_seq[1] = 3'd0;
    exp_seq[2] = 3'd6;
    do_reset(8'h40);
    wait_valid(ok, steps);
    req = 8'h00;
    repeat (3) @(negedge Clk);
    req = 8'b1100_0001;
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok, steps);
      checks++;
      if (!ok || gnt_id !== exp_seq[k]) begin
        errors++;
        $display("FAIL wrap_order %0d: gnt_id=%0d valid=%b, required %0d", k, gnt_id, gnt_valid, exp_seq[k]);
      end
      len = 0;
      while (gnt_valid && len < 20) begin
        @(negedge Clk);
        len++;
      end
    end
  endtask

  task automatic test_reset_mid_grant;
    bit ok;
    int steps;
    do_reset(8'h10);
    wait_valid(ok, steps);
    repeat (4) @(negedge Clk);
    checks++;
    if (gnt !== 8'h10) begin
      errors++;
      $display("FAIL mid_pre: gnt=%h, required 10 in 5th grant cycle", gnt);
    end
    #1 Reset = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h00 || count_reset !== 1'b1 || gnt_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: gnt=%h count_reset=%b valid=%b busy=%b, required 00 1 0 0",
               gnt, count_reset, gnt_valid, busy);
    end
    req = 8'h11;
    @(negedge Clk);
    Reset = 1'b0;
    wait_valid(ok, steps);
    checks++;
    if (!ok || gnt_id !== 3'd0 || gnt !== 8'h01) begin
      errors++;
      $display("FAIL mid_next: gnt_id=%0d gnt=%h, required 0 01", gnt_id, gnt);
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_single();
    test_all_requesting();
    test_early_drop();
    test_wrap_around();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter_8ch.md
Name: rr_grant_arbiter_8ch

Overview:
- Round-robin arbiter for the 8-channel datapath.
- Sits directly upstream of the grant-window counter, which is a free-running 0..9 counter with active-high async reset input count_reset. That counter returns gnt_done (count < 9) and count_done (count == 9).
- The arbiter picks one requesting channel, restarts the counter, and holds a one-hot grant for the counter's window. It then rotates priority to the next channel.

Parameters:
- NCH, 8, number of request channels (RTL written for 8; other values unsupported).
- IDW, 3, width of channel index (log2 NCH).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req  input  8  per-channel request, level-sensitive, held until served.
- gnt_done  input  1  from grant-window counter: high while count < 9.
- count_done  input  1  from grant-window counter: high when count == 9.
- count_reset  output  1  registered; restarts grant-window counter (async reset into counter).
- gnt  output  8  one-hot grant; all-zero when no grant.
- gnt_id  output  3  index of current/last granted channel.
- gnt_valid  output  1  high exactly when gnt != 0.
- busy  output  1  high in states START, GRANT, RELEASE.

Behaviour:
- Reset values (async, immediate on Reset=1):
  - state=IDLE, gnt_q=0, gnt=0, gnt_valid=0, busy=0.
  - count_reset=1 (async set, so the counter is held at 0 during reset).
  - last_id=7, so channel 0 has top priority after reset; gnt_id=0.
- Selection: the winner is the first channel with req=1, searching last_id+1, last_id+2, ... mod 8. This is combinational from the registered last_id and the sampled req.
- FSM, all transitions on rising Clk:
  - IDLE: count_reset=0. If req!=0, latch winner into win_id and go to START. Otherwise stay. count_done is ignored outside GRANT.
  - START: count_reset=1 for exactly this one cycle. Unconditionally go to GRANT and load gnt_q = one-hot(win_id). Requests are not re-sampled here.
  - GRANT: count_reset=0. The counter is at 0 in the first GRANT cycle and increments each edge.
    - count_done=1 → go to RELEASE.
    - Else if req[win_id]=0 (early drop) → go to RELEASE.
    - count_done takes precedence when both hold (same outcome).
  - RELEASE: gnt_q cleared. last_id <= win_id, gnt_id holds win_id.
    - If req has any bit set other than just-served priority considered (normal rotation from the new last_id) → latch new winner and go to START.
    - Else go to IDLE.
- Grant output: gnt = gnt_q & {8{gnt_done}} while state==GRANT, else 0. This is combinational qualification by gnt_done.
  - Full window: gnt high for 9 cycles (counter 0..8).
  - gnt low in the count_done cycle, which acts as the guard cycle.
- gnt_valid = |gnt.
- gnt_id updates when START is entered (gnt_id <= win_id).
- Back-to-back full windows: period of 12 cycles (START + 10 GRANT + RELEASE). gnt is low for 3 cycles between windows.
- A req bit dropped by a channel that is not granted has no effect. A re-raised req competes normally.
- Reset mid-operation: all outputs go to reset values at once, and the grant is lost without a RELEASE. The next arbitration starts from channel 0.
- Upstream counter misbehaviour: if the counter misses count_done, the grant persists until req[win_id] drops. No watchdog in this block.

Test Plan:
- Reset: hold Reset=1 with req=8'hFF → gnt=0, gnt_valid=0, busy=0, count_reset=1. After release, the first grant is channel 0 (gnt=8'h01, gnt_id=0).
- Single requester: req=8'h08 held → START with count_reset=1 for 1 cycle. Then gnt=8'h08 for 9 cycles, gnt=0 on the count_done cycle, RELEASE, and START again. Period is 12 cycles.
- All requesting: req=8'hFF held → gnt_id sequence 0,1,2,3,4,5,6,7,0. Each window is 9 gnt cycles with a 3-cycle gap.
- Early drop: req=8'h20, deassert req[5] after 4 gnt cycles → gnt stays 8'h20 in the drop cycle and goes to 0 next cycle (RELEASE). Then IDLE, busy=0, last_id=5.
- Wrap-around: last_id=6, req=8'b1100_0001 held → grants 7, 0, 6 in that order.
- Reset mid-GRANT: pulse Reset during the 5th gnt cycle of channel 4 → gnt=0 and count_reset=1 asynchronously. With req=8'h11, the next grant goes to channel 0, not channel 4.
